// File: rtl/matvec_ctrl.sv
// rtl/matvec_ctrl.sv - control FSM and address sequencer for the MxM signed matrix-vector multiply
// Loads matrix/vector words, sweeps one row per pass through the MAC, and holds each row until accepted.
module matvec_ctrl #(
    parameter int M       = 8,
    parameter int MEM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     input_valid,
    output logic                     input_ready,
    input  logic                     new_matrix,
    output logic                     wr_en_m,
    output logic [$clog2(M*M)-1:0]   wr_addr_m,
    output logic                     wr_en_x,
    output logic [$clog2(M)-1:0]     wr_addr_x,
    output logic [$clog2(M*M)-1:0]   rd_addr_m,
    output logic [$clog2(M)-1:0]     rd_addr_x,
    output logic                     en_acc,
    output logic                     clear_acc,
    output logic                     output_valid,
    input  logic                     output_ready,
    output logic                     matrix_loaded
);

    localparam int AW_M = $clog2(M*M);
    localparam int AW_X = $clog2(M);
    localparam logic [AW_M-1:0] LAST_M = AW_M'(M*M-1);
    localparam logic [AW_X-1:0] LAST_X = AW_X'(M-1);
    // Every pipeline stage except the oldest, which is the one driving en_acc.
    localparam logic [MEM_LAT-1:0] PEND_MASK = {MEM_LAT{1'b1}} >> 1;

    typedef enum logic [2:0] {
        FIRST,
        LOAD_M,
        LOAD_X,
        COMPUTE,
        DRAIN,
        OUT_WAIT
    } state_t;

    state_t             state, state_n;
    logic [AW_M-1:0]    mcnt, mcnt_n;
    logic [AW_X-1:0]    xcnt, xcnt_n;
    logic [AW_X-1:0]    row, row_n;
    logic [AW_X-1:0]    k, k_n;
    logic               loaded_n;
    logic [MEM_LAT-1:0] vpipe, vpipe_n;
    logic [MEM_LAT-1:0] cpipe, cpipe_n;
    logic               in_xfer;
    logic               out_xfer;
    logic               issue;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= FIRST;
            mcnt          <= '0;
            xcnt          <= '0;
            row           <= '0;
            k             <= '0;
            matrix_loaded <= 1'b0;
            vpipe         <= '0;
            cpipe         <= '0;
        end else begin
            state         <= state_n;
            mcnt          <= mcnt_n;
            xcnt          <= xcnt_n;
            row           <= row_n;
            k             <= k_n;
            matrix_loaded <= loaded_n;
            vpipe         <= vpipe_n;
            cpipe         <= cpipe_n;
        end
    end

    always_comb begin
        state_n      = state;
        mcnt_n       = mcnt;
        xcnt_n       = xcnt;
        row_n        = row;
        k_n          = k;
        loaded_n     = matrix_loaded;
        issue        = 1'b0;
        // Gated by reset so nothing is accepted while the block is being cleared.
        input_ready  = !reset && (state == FIRST || state == LOAD_M || state == LOAD_X);
        in_xfer      = input_valid && input_ready;
        output_valid = (state == OUT_WAIT);
        out_xfer     = output_valid && output_ready;
        wr_en_m      = 1'b0;
        wr_addr_m    = mcnt;
        wr_en_x      = 1'b0;
        wr_addr_x    = xcnt;

        case (state)
            FIRST: begin
                if (in_xfer) begin
                    if (new_matrix || !matrix_loaded) begin
                        wr_en_m   = 1'b1;
                        wr_addr_m = '0;
                        mcnt_n    = AW_M'(1);
                        state_n   = LOAD_M;
                    end else begin
                        wr_en_x   = 1'b1;
                        wr_addr_x = '0;
                        xcnt_n    = AW_X'(1);
                        state_n   = LOAD_X;
                    end
                end
            end
            LOAD_M: begin
                wr_en_m = in_xfer;
                if (in_xfer) begin
                    mcnt_n = mcnt + 1'b1;
                    if (mcnt == LAST_M) begin
                        mcnt_n   = '0;
                        loaded_n = 1'b1;
                        xcnt_n   = '0;
                        state_n  = LOAD_X;
                    end
                end
            end
            LOAD_X: begin
                wr_en_x = in_xfer;
                if (in_xfer) begin
                    xcnt_n = xcnt + 1'b1;
                    if (xcnt == LAST_X) begin
                        xcnt_n  = '0;
                        row_n   = '0;
                        k_n     = '0;
                        state_n = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                issue = 1'b1;
                // k parks on the last column so the addresses hold through DRAIN/OUT_WAIT.
                if (k == LAST_X) begin
                    state_n = DRAIN;
                end else begin
                    k_n = k + 1'b1;
                end
            end
            DRAIN: begin
                if ((vpipe & PEND_MASK) == '0) begin
                    state_n = OUT_WAIT;
                end
            end
            OUT_WAIT: begin
                if (out_xfer) begin
                    k_n = '0;
                    if (row == LAST_X) begin
                        row_n   = '0;
                        state_n = FIRST;
                    end else begin
                        row_n   = row + 1'b1;
                        state_n = COMPUTE;
                    end
                end
            end
            default: state_n = FIRST;
        endcase

        vpipe_n    = vpipe << 1;
        vpipe_n[0] = issue;
        cpipe_n    = cpipe << 1;
        cpipe_n[0] = issue && (k == '0);
    end

    assign en_acc    = vpipe[MEM_LAT-1];
    assign clear_acc = cpipe[MEM_LAT-1];
    assign rd_addr_x = k;

    generate
        if ((M & (M - 1)) == 0) begin : g_pow2
            assign rd_addr_m = {row, k};
        end else begin : g_mul
            assign rd_addr_m = AW_M'(int'(row) * M + int'(k));
        end
    endgenerate

endmodule

// File: doc/matvec_ctrl.md
Name: matvec_ctrl

Overview:
- Control FSM and address sequencer for the 8x8 signed matrix-vector multiply datapath (14-bit operands, 28-bit accumulator).
- Owns the input and output valid/ready handshakes, generates matrix/vector memory write and read addresses, and drives MAC clear/enable.
- Computes one output row at a time; the datapath holds that row in the accumulator until it is accepted.
- Carries no data itself; sits between the testbench-facing ports and the memories/MAC.

Parameters:
- M, 8: matrix dimension; the matrix is MxM and the vector has M entries.
- MEM_LAT, 1: memory read latency in cycles, from address to data at the MAC inputs (>=1).

Ports:
- clk  in  1  clock; all logic is on posedge.
- reset  in  1  synchronous, active-high reset.
- input_valid  in  1  upstream word valid.
- input_ready  out  1  controller accepts a word this cycle.
- new_matrix  in  1  sampled only on the first word of a problem; 1 means a matrix follows.
- wr_en_m  out  1  matrix memory write enable.
- wr_addr_m  out  $clog2(M*M)  matrix write address, row-major.
- wr_en_x  out  1  vector memory write enable.
- wr_addr_x  out  $clog2(M)  vector write address.
- rd_addr_m  out  $clog2(M*M)  matrix read address.
- rd_addr_x  out  $clog2(M)  vector read address.
- en_acc  out  1  MAC update this cycle.
- clear_acc  out  1  with en_acc, acc <= product; without it, acc <= acc + product.
- output_valid  out  1  accumulator holds a finished row.
- output_ready  in  1  downstream accepts the row.
- matrix_loaded  out  1  a complete matrix has been stored since reset.

Behaviour:
- Handshake: a word transfers when input_valid && input_ready; a row transfers when output_valid && output_ready. Counters advance only on transfers.
- States: FIRST, LOAD_M, LOAD_X, COMPUTE, DRAIN, OUT_WAIT.
- Reset (synchronous, any state): next state FIRST. All outputs 0, except input_ready=1 from the first cycle after reset deasserts. matrix_loaded=0 and all counters 0. Reset mid-load or mid-compute abandons the problem.
- FIRST: input_ready=1.
  - On transfer with new_matrix==1 or matrix_loaded==0: write m[0] and go to LOAD_M with mcnt=1. new_matrix==0 before any matrix is loaded is treated as 1.
  - Otherwise: write x[0] and go to LOAD_X with xcnt=1.
- LOAD_M: input_ready=1. wr_en_m=transfer and wr_addr_m=mcnt (combinational from the handshake). new_matrix is ignored. On the transfer of word M*M-1: matrix_loaded<=1, go to LOAD_X with xcnt=0.
- LOAD_X: input_ready=1. wr_en_x=transfer and wr_addr_x=xcnt. On the transfer of word M-1: go to COMPUTE with row r=0 and k=0.
- input_ready=0 in COMPUTE, DRAIN and OUT_WAIT. Write enables are 0 outside transfers.
- COMPUTE: one address pair per cycle, rd_addr_m=r*M+k and rd_addr_x=k, for k=0..M-1. After k=M-1, go to DRAIN.
- en_acc pipeline: a valid bit is delayed MEM_LAT cycles. en_acc is issue-valid delayed by MEM_LAT; clear_acc is the same pulse gated by k==0.
- DRAIN: waits until the last en_acc has fired, then output_valid<=1 on the next cycle and the state goes to OUT_WAIT.
- OUT_WAIT: output_valid is held at 1, read addresses are held, en_acc=0.
  - On row transfer with r<M-1: r++, k=0, go to COMPUTE, and output_valid drops the next cycle.
  - On row transfer with r==M-1: go to FIRST.
- Latency:
  - Last vector word accepted at cycle t: first read address at t+1, first en_acc at t+1+MEM_LAT, output_valid at t+M+MEM_LAT+1. For M=8, MEM_LAT=1 this is t+10.
  - Row accepted at cycle u: next output_valid at u+M+MEM_LAT+1.
- No overlap: a new problem is not accepted until all M rows are drained. output_valid never rises without a pending row.
- Address widths: row-major r*M+k is formed with shift/concatenation when M is a power of two. M must be >=2.

Test Plan:
1. Reset, then 72 words with input_valid held 1 and new_matrix=1 on word 0 -> wr_en_m pulses 64 times (addr 0..63) and wr_en_x 8 times (addr 0..7). input_ready=0 the cycle after word 71. output_valid at t+10. Eight rows then read out with output_ready=1; input_ready returns to 1.
2. Backpressure: hold output_ready=0 for 5 cycles while row 3 is valid -> output_valid stays 1, en_acc=0, rd addrs stable; exactly 8 row transfers in total.
3. Matrix reuse: second problem with new_matrix=0 on its first word -> only 8 words accepted and wr_en_m never asserted. rd_addr_m sweeps 0..63 again; matrix_loaded stays 1.
4. First word after reset carries new_matrix=0 -> treated as a matrix: 64 wr_en_m pulses, then 8 wr_en_x.
5. Reset asserted during COMPUTE of row 4 -> next cycle all outputs 0 and matrix_loaded=0. input_ready=1 the cycle after reset drops; no further output_valid.
6. Random input_valid gaps and X on new_matrix for non-first words -> addresses advance only on transfers. No X propagates to the write enables or addresses, and the counts match scenario 1.
